// File: rtl/core_irq_pkg.sv
// Shared definitions for the core-side interrupt controller:
// table geometry, trigger encodings, FSM states and event helpers.
package core_irq_pkg;

    localparam int unsigned IRQ_ENTRIES = 64;
    localparam int unsigned IRQ_IDX_W   = 6;

    localparam logic [1:0] IRQ_RISE = 2'b00;
    localparam logic [1:0] IRQ_FALL = 2'b01;
    localparam logic [1:0] IRQ_HIGH = 2'b10;
    localparam logic [1:0] IRQ_LOW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    // Level types are distinguished by the upper bit of the trigger field.
    function automatic logic is_level_type(input logic [1:0] lvl);
        return lvl[1];
    endfunction

    function automatic logic level_active(input logic [1:0] lvl, input logic line);
        logic act;
        act = 1'b0;
        case (lvl)
            IRQ_HIGH: act = line;
            IRQ_LOW:  act = ~line;
            default:  act = 1'b0;
        endcase
        return act;
    endfunction

    function automatic logic edge_event(input logic [1:0] lvl, input logic line_now,
                                        input logic line_prev);
        logic ev;
        ev = 1'b0;
        case (lvl)
            IRQ_RISE: ev = line_now & ~line_prev;
            IRQ_FALL: ev = ~line_now & line_prev;
            default:  ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/core_irq_prio_enc.sv
// Lowest-index-first priority encoder over the pending vector.
// Purely combinational; idx is 0 when nothing is found.
module core_irq_prio_enc
    import core_irq_pkg::*;
(
    input  logic [IRQ_ENTRIES-1:0] req_vec,
    output logic                   found,
    output logic [IRQ_IDX_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < IRQ_ENTRIES; i++) begin
            if (!found && req_vec[i]) begin
                found = 1'b1;
                idx   = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/core_irq_controller.sv
// Core-side interrupt controller: 64-entry config table, edge/level pending
// capture, lowest-index arbitration and a valid/num/ack handshake to the core.
module core_irq_controller
    import core_irq_pkg::*;
#(
    parameter int unsigned ACK_GAP = 1
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic [63:0] iIRQ_LINE,
    input  logic        iIO_IRQ_CONFIG_TABLE_REQ,
    input  logic [5:0]  iIO_IRQ_CONFIG_TABLE_ENTRY,
    input  logic        iIO_IRQ_CONFIG_TABLE_FLAG_MASK,
    input  logic        iIO_IRQ_CONFIG_TABLE_FLAG_VALID,
    input  logic [1:0]  iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL,
    output logic        oINTERRUPT_VALID,
    output logic [5:0]  oINTERRUPT_NUM,
    input  logic        iINTERRUPT_ACK
);

    logic [IRQ_ENTRIES-1:0]      valid_q, valid_d;
    logic [IRQ_ENTRIES-1:0]      mask_q, mask_d;
    logic [IRQ_ENTRIES-1:0][1:0] level_q, level_d;
    logic [IRQ_ENTRIES-1:0]      line_q;
    logic [IRQ_ENTRIES-1:0]      pending_q, pending_d;
    logic [IRQ_ENTRIES-1:0]      eligible;

    irq_state_e                  state_q, state_d;
    logic                        int_valid_q, int_valid_d;
    logic [IRQ_IDX_W-1:0]        int_num_q, int_num_d;
    logic [3:0]                  gap_cnt_q, gap_cnt_d;

    logic                        found;
    logic [IRQ_IDX_W-1:0]        found_idx;
    logic                        ack_take;

    assign eligible = valid_q & ~mask_q;
    assign ack_take = (state_q == REQ) && iINTERRUPT_ACK;

    always_comb begin
        valid_d = valid_q;
        mask_d  = mask_q;
        level_d = level_q;
        if (iIO_IRQ_CONFIG_TABLE_REQ) begin
            valid_d[iIO_IRQ_CONFIG_TABLE_ENTRY] = iIO_IRQ_CONFIG_TABLE_FLAG_VALID;
            mask_d[iIO_IRQ_CONFIG_TABLE_ENTRY]  = iIO_IRQ_CONFIG_TABLE_FLAG_MASK;
            level_d[iIO_IRQ_CONFIG_TABLE_ENTRY] = iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL;
        end
    end

    // Priority per entry: write clear > new edge event > ack clear > hold.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned n = 0; n < IRQ_ENTRIES; n++) begin
            if (is_level_type(level_q[n])) begin
                pending_d[n] = eligible[n] & level_active(level_q[n], iIRQ_LINE[n]);
            end else begin
                if (ack_take && (int_num_q == IRQ_IDX_W'(n))) begin
                    pending_d[n] = 1'b0;
                end
                if (eligible[n] && edge_event(level_q[n], iIRQ_LINE[n], line_q[n])) begin
                    pending_d[n] = 1'b1;
                end
            end
            if (iIO_IRQ_CONFIG_TABLE_REQ && (iIO_IRQ_CONFIG_TABLE_ENTRY == IRQ_IDX_W'(n))) begin
                pending_d[n] = 1'b0;
            end
        end
    end

    core_irq_prio_enc u_prio_enc (
        .req_vec (pending_q),
        .found   (found),
        .idx     (found_idx)
    );

    // Once presented, an interrupt is held until acked regardless of table or line changes.
    always_comb begin
        state_d     = state_q;
        int_valid_d = int_valid_q;
        int_num_d   = int_num_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    int_valid_d = 1'b1;
                    int_num_d   = found_idx;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (iINTERRUPT_ACK) begin
                    int_valid_d = 1'b0;
                    if (ACK_GAP > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = 4'(ACK_GAP - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                int_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            valid_q     <= '0;
            mask_q      <= '1;
            level_q     <= '0;
            line_q      <= '0;
            pending_q   <= '0;
            state_q     <= IDLE;
            int_valid_q <= 1'b0;
            int_num_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            level_q     <= level_d;
            line_q      <= iIRQ_LINE;
            pending_q   <= pending_d;
            state_q     <= state_d;
            int_valid_q <= int_valid_d;
            int_num_q   <= int_num_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign oINTERRUPT_VALID = int_valid_q;
    assign oINTERRUPT_NUM   = int_num_q;

endmodule

// File: tb/tb_core_irq_controller.sv
// Directed bench for core_irq_controller: expected outputs are queued as each
// step is driven and compared one cycle later against the DUT.
module tb_core_irq_controller;
    import core_irq_pkg::*;

    logic        iCLOCK;
    logic        inRESET;
    logic [63:0] iIRQ_LINE;
    logic        iIO_IRQ_CONFIG_TABLE_REQ;
    logic [5:0]  iIO_IRQ_CONFIG_TABLE_ENTRY;
    logic        iIO_IRQ_CONFIG_TABLE_FLAG_MASK;
    logic        iIO_IRQ_CONFIG_TABLE_FLAG_VALID;
    logic [1:0]  iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL;
    logic        oINTERRUPT_VALID;
    logic [5:0]  oINTERRUPT_NUM;
    logic        iINTERRUPT_ACK;

    int unsigned vectors;
    int unsigned miscompares;

    typedef struct {
        string      tag;
        logic       v;
        logic [5:0] n;
    } exp_t;

    exp_t sb[$];

    core_irq_controller #(.ACK_GAP(1)) dut (
        .iCLOCK                          (iCLOCK),
        .inRESET                         (inRESET),
        .iIRQ_LINE                       (iIRQ_LINE),
        .iIO_IRQ_CONFIG_TABLE_REQ        (iIO_IRQ_CONFIG_TABLE_REQ),
        .iIO_IRQ_CONFIG_TABLE_ENTRY      (iIO_IRQ_CONFIG_TABLE_ENTRY),
        .iIO_IRQ_CONFIG_TABLE_FLAG_MASK  (iIO_IRQ_CONFIG_TABLE_FLAG_MASK),
        .iIO_IRQ_CONFIG_TABLE_FLAG_VALID (iIO_IRQ_CONFIG_TABLE_FLAG_VALID),
        .iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL (iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL),
        .oINTERRUPT_VALID                (oINTERRUPT_VALID),
        .oINTERRUPT_NUM                  (oINTERRUPT_NUM),
        .iINTERRUPT_ACK                  (iINTERRUPT_ACK)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    task automatic push(input string tag, input logic v, input logic [5:0] n);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.n   = n;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed valid=%0b num=%0d, expected a queued entry",
                   oINTERRUPT_VALID, oINTERRUPT_NUM);
        end else begin
            e = sb.pop_front();
            assert ({oINTERRUPT_VALID, oINTERRUPT_NUM} === {e.v, e.n})
            else begin
                miscompares++;
                $error("FAIL %s: observed valid=%0b num=%0d, expected valid=%0b num=%0d",
                       e.tag, oINTERRUPT_VALID, oINTERRUPT_NUM, e.v, e.n);
            end
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [5:0] n);
        push(tag, v, n);
        tick();
        check_out();
    endtask

    task automatic wr(input logic [5:0] entry, input logic valid, input logic mask,
                      input logic [1:0] lvl);
        iIO_IRQ_CONFIG_TABLE_REQ        = 1'b1;
        iIO_IRQ_CONFIG_TABLE_ENTRY      = entry;
        iIO_IRQ_CONFIG_TABLE_FLAG_VALID = valid;
        iIO_IRQ_CONFIG_TABLE_FLAG_MASK  = mask;
        iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL = lvl;
        tick();
        iIO_IRQ_CONFIG_TABLE_REQ        = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        inRESET                         = 1'b0;
        iIRQ_LINE                       = '0;
        iIO_IRQ_CONFIG_TABLE_REQ        = 1'b0;
        iIO_IRQ_CONFIG_TABLE_ENTRY      = '0;
        iIO_IRQ_CONFIG_TABLE_FLAG_MASK  = 1'b0;
        iIO_IRQ_CONFIG_TABLE_FLAG_VALID = 1'b0;
        iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL = 2'b00;
        iINTERRUPT_ACK                  = 1'b0;

        #3;
        push("reset_state", 1'b0, 6'd0);
        check_out();
        repeat (2) tick();
        inRESET = 1'b1;
        tick();

        // Single rising-edge IRQ 5
        wr(6'd5, 1'b1, 1'b0, IRQ_RISE);
        iIRQ_LINE[5] = 1'b1;
        step("e5_pending_edge", 1'b0, 6'd0);
        iIRQ_LINE[5] = 1'b0;
        step("e5_present", 1'b1, 6'd5);
        step("e5_hold", 1'b1, 6'd5);
        iINTERRUPT_ACK = 1'b1;
        step("e5_ack", 1'b0, 6'd5);
        iINTERRUPT_ACK = 1'b0;
        step("e5_gap", 1'b0, 6'd5);
        step("e5_no_repeat0", 1'b0, 6'd5);
        step("e5_no_repeat1", 1'b0, 6'd5);

        // Simultaneous IRQs 3 and 40: lowest index first
        wr(6'd3, 1'b1, 1'b0, IRQ_RISE);
        wr(6'd40, 1'b1, 1'b0, IRQ_RISE);
        iIRQ_LINE[3]  = 1'b1;
        iIRQ_LINE[40] = 1'b1;
        step("p3_40_capture", 1'b0, 6'd5);
        iIRQ_LINE[3]  = 1'b0;
        iIRQ_LINE[40] = 1'b0;
        step("p3_first", 1'b1, 6'd3);
        iINTERRUPT_ACK = 1'b1;
        step("p3_ack", 1'b0, 6'd3);
        iINTERRUPT_ACK = 1'b0;
        step("p3_gap", 1'b0, 6'd3);
        step("p40_second", 1'b1, 6'd40);
        iINTERRUPT_ACK = 1'b1;
        step("p40_ack", 1'b0, 6'd40);
        iINTERRUPT_ACK = 1'b0;
        step("p40_gap", 1'b0, 6'd40);
        step("p40_idle", 1'b0, 6'd40);

        // High-level IRQ 7: re-presented while active, no retraction when dropped
        wr(6'd7, 1'b1, 1'b0, IRQ_HIGH);
        iIRQ_LINE[7] = 1'b1;
        step("l7_capture", 1'b0, 6'd40);
        step("l7_present", 1'b1, 6'd7);
        iINTERRUPT_ACK = 1'b1;
        step("l7_ack", 1'b0, 6'd7);
        iINTERRUPT_ACK = 1'b0;
        step("l7_gap", 1'b0, 6'd7);
        step("l7_represent", 1'b1, 6'd7);
        iIRQ_LINE[7] = 1'b0;
        step("l7_no_retract0", 1'b1, 6'd7);
        step("l7_no_retract1", 1'b1, 6'd7);
        iINTERRUPT_ACK = 1'b1;
        step("l7_ack2", 1'b0, 6'd7);
        iINTERRUPT_ACK = 1'b0;
        step("l7_gap2", 1'b0, 6'd7);
        step("l7_gone0", 1'b0, 6'd7);
        iINTERRUPT_ACK = 1'b1;
        step("ack_while_idle", 1'b0, 6'd7);
        iINTERRUPT_ACK = 1'b0;
        step("l7_gone1", 1'b0, 6'd7);

        // Masked edge on IRQ 9 is discarded
        wr(6'd9, 1'b1, 1'b1, IRQ_RISE);
        iIRQ_LINE[9] = 1'b1;
        step("m9_masked_edge", 1'b0, 6'd7);
        iIRQ_LINE[9] = 1'b0;
        step("m9_masked_idle", 1'b0, 6'd7);
        wr(6'd9, 1'b1, 1'b0, IRQ_RISE);
        step("m9_unmasked0", 1'b0, 6'd7);
        step("m9_unmasked1", 1'b0, 6'd7);

        // New edge on the ack cycle survives the ack
        wr(6'd12, 1'b1, 1'b0, IRQ_RISE);
        iIRQ_LINE[12] = 1'b1;
        step("r12_capture", 1'b0, 6'd7);
        iIRQ_LINE[12] = 1'b0;
        step("r12_present", 1'b1, 6'd12);
        iINTERRUPT_ACK = 1'b1;
        iIRQ_LINE[12]  = 1'b1;
        step("r12_ack_and_edge", 1'b0, 6'd12);
        iINTERRUPT_ACK = 1'b0;
        iIRQ_LINE[12]  = 1'b0;
        step("r12_gap", 1'b0, 6'd12);
        step("r12_represent", 1'b1, 6'd12);
        iINTERRUPT_ACK = 1'b1;
        step("r12_ack2", 1'b0, 6'd12);
        iINTERRUPT_ACK = 1'b0;
        step("r12_gap2", 1'b0, 6'd12);
        step("r12_idle", 1'b0, 6'd12);

        // Table write on the ack cycle clears the pending bit
        wr(6'd20, 1'b1, 1'b0, IRQ_RISE);
        iIRQ_LINE[20] = 1'b1;
        step("w20_capture", 1'b0, 6'd12);
        iIRQ_LINE[20] = 1'b0;
        step("w20_present", 1'b1, 6'd20);
        iINTERRUPT_ACK                  = 1'b1;
        iIO_IRQ_CONFIG_TABLE_REQ        = 1'b1;
        iIO_IRQ_CONFIG_TABLE_ENTRY      = 6'd20;
        iIO_IRQ_CONFIG_TABLE_FLAG_VALID = 1'b1;
        iIO_IRQ_CONFIG_TABLE_FLAG_MASK  = 1'b0;
        iIO_IRQ_CONFIG_TABLE_FLAG_LEVEL = IRQ_RISE;
        step("w20_ack_write", 1'b0, 6'd20);
        iINTERRUPT_ACK           = 1'b0;
        iIO_IRQ_CONFIG_TABLE_REQ = 1'b0;
        step("w20_gap", 1'b0, 6'd20);
        step("w20_idle0", 1'b0, 6'd20);
        step("w20_idle1", 1'b0, 6'd20);

        // Async reset while presenting
        wr(6'd30, 1'b1, 1'b0, IRQ_HIGH);
        iIRQ_LINE[30] = 1'b1;
        step("l30_capture", 1'b0, 6'd20);
        step("l30_present", 1'b1, 6'd30);
        #2;
        inRESET = 1'b0;
        #1;
        push("async_reset", 1'b0, 6'd0);
        check_out();
        step("reset_hold", 1'b0, 6'd0);
        inRESET = 1'b1;
        step("post_reset0", 1'b0, 6'd0);
        iIRQ_LINE[5] = 1'b1;
        step("post_reset_edge5", 1'b0, 6'd0);
        iIRQ_LINE[5] = 1'b0;
        step("post_reset1", 1'b0, 6'd0);
        step("post_reset2", 1'b0, 6'd0);
        step("post_reset3", 1'b0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
